// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory, write-back.
// Moore-style control decode from the registered state, with a per-access ack timeout.
//
//  state  | meaning
//  IDLE   | halted, waits for run=1
//  FETCH  | imem_req held until imem_ack; IR loads on ack
//  DECODE | register read / immediate generation, opcode legality check
//  EXEC   | ALU cycle; branches resolve and retire here
//  MEM    | dmem_req held until dmem_ack; stores retire here
//  WB     | register-file write, PC update, retire
//  FAULT  | illegal opcode or ack timeout; left only by rst
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        regWrite,
    output logic        MemtoReg,
    output logic        busy,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             timed_out;

    // The cycle that would bring the counter to TIMEOUT is the last one allowed.
    assign timed_out = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        regWrite = 1'b0;
        MemtoReg = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
                if (imem_ack)       state_d = S_DECODE;
                else if (timed_out) state_d = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OPIMM,
                    OP_BRANCH, OP_LOAD, OP_STORE: state_d = S_EXEC;
                    OP_SYSTEM: begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken;
                        retire  = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ack) begin
                    if (opcode == OP_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                MemtoReg = (opcode == OP_LOAD);
                pc_we    = 1'b1;
                pc_sel   = (opcode == OP_JAL) || (opcode == OP_JALR);
                retire   = 1'b1;
                state_d  = run ? S_FETCH : S_IDLE;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            // Any state change clears the counter, which covers entry into FETCH and MEM.
            if (state_d != state_q)
                cnt_q <= '0;
            else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack))
                cnt_q <= cnt_q + 1'b1;
            if (retire)
                instret <= instret + 32'd1;
        end
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault = (state_q == S_FAULT);
    assign state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath: instruction fetch, decoder/register-file read, ALU, data memory and write-back. Moore FSM that sequences one instruction at a time. Drives register-file regWrite/MemtoReg, IR/PC write enables and req/ack handshakes to instruction and data memory. Sits between the top-level CPU wrapper and the Decoder/ALU/memory blocks.

Parameters:
TIMEOUT, 255, max cycles a memory req may wait for ack before FAULT
CNT_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
run  in  1  level enable; IDLE leaves only when run=1
opcode  in  7  inst[6:0] from the IR
branch_taken  in  1  ALU compare result, valid in EXEC
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid; IR captures the same cycle
dmem_req  out  1  data memory request
dmem_we  out  1  1=store, 0=load; valid while dmem_req=1
dmem_ack  in  1  data access complete / load data valid
ir_we  out  1  IR load enable
pc_we  out  1  PC update enable
pc_sel  out  1  0=pc+4, 1=target (branch/jal/jalr)
regWrite  out  1  register-file write enable
MemtoReg  out  1  write-back source: 1=memory data
busy  out  1  high in every state except IDLE and FAULT
fault  out  1  sticky error flag
state  out  3  current state encoding, for debug
instret  out  32  retired-instruction counter

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. State and counters are registered. All control outputs decode combinationally from state plus opcode/branch_taken/ack. No combinational path from run.
- Reset (rst=1 at an edge): state=IDLE, instret=0, fault=0, timeout counter=0. All outputs are 0 during and after reset. Reset mid-access abandons the request: req drops the next cycle with no wait for ack.
- IDLE: run=1 -> FETCH.
- FETCH:
  - imem_req=1.
  - ir_we=imem_ack.
  - On ack -> DECODE, else stay.
  - An ack in the first FETCH cycle is legal, giving a 1-cycle fetch.
- DECODE (1 cycle): register read and immediate generation. Next state by opcode:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP 0110011, OP-IMM 0010011 -> EXEC.
  - BRANCH 1100011, LOAD 0000011, STORE 0100011 -> EXEC.
  - SYSTEM 1110011 (ecall/ebreak) -> IDLE, retires (instret+1), pc_we=0.
  - Any other opcode -> FAULT.
- EXEC (1 cycle):
  - LOAD/STORE -> MEM.
  - BRANCH: pc_we=1, pc_sel=branch_taken, instret+1. Then run=1 -> FETCH, run=0 -> IDLE.
  - All others -> WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE, 0 for LOAD. req held until ack; ack in the same cycle as req counts.
  - STORE with ack: pc_we=1, pc_sel=0, instret+1, then FETCH/IDLE per run.
  - LOAD with ack -> WB.
- WB (1 cycle):
  - regWrite=1. MemtoReg=1 only for LOAD.
  - pc_we=1. pc_sel=1 for JAL/JALR, 0 otherwise.
  - instret+1, then FETCH if run=1, else IDLE.
- Timeout:
  - Counter clears on entering FETCH/MEM and increments each cycle req=1 and ack=0.
  - Reaching TIMEOUT -> FAULT; the req drops the next cycle.
- FAULT: fault=1, all enables 0, busy=0. Left only by rst.
- Invariants:
  - regWrite, pc_we and ir_we are never high more than 1 cycle per instruction.
  - regWrite is never high for STORE, BRANCH or SYSTEM.
  - imem_req and dmem_req are never high together.
- run is sampled only at instruction boundaries. Deasserting run mid-instruction completes that instruction, then goes to IDLE.
- instret wraps from 0xFFFFFFFF to 0.
- ack while no req is ignored.

Test Plan:
- rst held 3 cycles with run=1 -> all outputs 0 and state=0. Release -> FETCH next edge.
- ADDI (opcode 0010011), imem_ack 1 cycle after req -> sequence FETCH,FETCH,DECODE,EXEC,WB. regWrite=1, MemtoReg=0 in WB only. instret 0->1.
- LW, dmem_ack delayed 4 cycles -> dmem_req high 5 cycles with dmem_we=0. WB has MemtoReg=1, regWrite=1. STORE with 0-wait ack -> one MEM cycle with dmem_we=1, pc_we=1, no regWrite.
- BEQ with branch_taken=1, then 0 -> pc_we=1 in EXEC with pc_sel=1, then 0. regWrite never asserted. JAL -> pc_sel=1 in WB.
- Illegal opcode 0000000 -> FAULT after DECODE, fault=1, busy=0. Stays there until rst.
- TIMEOUT=4, imem_ack held 0 -> FAULT exactly 4 cycles after FETCH entry. Separately: rst in MEM -> dmem_req low the next cycle. Separately: run dropped during EXEC -> IDLE after WB.
